// File: rtl/random_range.sv
// Returns one value uniformly distributed in [0, limit) by rejection sampling a
// free-running random word, with a single-subtraction fallback that bounds latency.
module random_range #(
    parameter int unsigned GAP       = 16,
    parameter int unsigned MAX_TRIES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] random,
    input  logic        req,
    input  logic [15:0] limit,
    output logic        busy,
    output logic        valid,
    output logic [15:0] value,
    output logic        fallback
);

    typedef enum logic [2:0] {IDLE, MASK, DRAW, REDUCE, DONE} state_t;

    localparam logic [15:0] GAP_RELOAD = 16'(GAP - 1);
    localparam logic [7:0]  LAST_TRY   = 8'(MAX_TRIES - 1);

    state_t      state_q;
    logic [15:0] lim_q;
    logic [15:0] mask_q;
    logic [15:0] gap_q;
    logic [7:0]  try_q;
    logic [15:0] cand_q;
    logic [15:0] value_q;
    logic        valid_q;
    logic        busy_q;
    logic        fallback_q;

    logic [15:0] mask_d;
    logic [15:0] cand;
    logic        accept;

    // Smear the top set bit of (lim-1) downwards; lim==0 wraps to all ones.
    always_comb begin
        mask_d = lim_q - 16'd1;
        mask_d = mask_d | (mask_d >> 1);
        mask_d = mask_d | (mask_d >> 2);
        mask_d = mask_d | (mask_d >> 4);
        mask_d = mask_d | (mask_d >> 8);
        cand   = random & mask_q;
        accept = (lim_q == '0) || (cand < lim_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            lim_q      <= '0;
            mask_q     <= '0;
            gap_q      <= '0;
            try_q      <= '0;
            cand_q     <= '0;
            value_q    <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            fallback_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (req) begin
                        lim_q   <= limit;
                        busy_q  <= 1'b1;
                        state_q <= MASK;
                    end
                end
                MASK: begin
                    mask_q  <= mask_d;
                    gap_q   <= GAP_RELOAD;
                    try_q   <= '0;
                    state_q <= DRAW;
                end
                DRAW: begin
                    if (gap_q != '0) begin
                        gap_q <= gap_q - 16'd1;
                    end else if (accept) begin
                        value_q    <= cand;
                        fallback_q <= 1'b0;
                        valid_q    <= 1'b1;
                        state_q    <= DONE;
                    end else if (try_q == LAST_TRY) begin
                        cand_q  <= cand;
                        state_q <= REDUCE;
                    end else begin
                        try_q <= try_q + 8'd1;
                        gap_q <= GAP_RELOAD;
                    end
                end
                REDUCE: begin
                    // mask < 2*lim, so one subtraction always lands in range.
                    value_q    <= cand_q - lim_q;
                    fallback_q <= 1'b1;
                    valid_q    <= 1'b1;
                    state_q    <= DONE;
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy     = busy_q;
    assign valid    = valid_q;
    assign value    = value_q;
    assign fallback = fallback_q;

endmodule

// File: tb/tb_random_range.sv
// Self-checking bench for random_range: directed boundary cases plus randomized
// transactions against a rejection-sampling reference model.
module tb_random_range;

    localparam int unsigned GAP       = 16;
    localparam int unsigned MAX_TRIES = 8;
    localparam int          MAXE      = MAX_TRIES * GAP + 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] random = '0;
    logic        req = 1'b0;
    logic [15:0] limit = '0;
    logic        busy;
    logic        valid;
    logic [15:0] value;
    logic        fallback;

    int          vectors = 0;
    int          errors  = 0;
    int          rnd_mode = 0;
    logic [15:0] rnd_const = '0;
    logic [15:0] lfsr = 16'hACE1;
    logic [15:0] samp [0:MAXE];

    random_range #(.GAP(GAP), .MAX_TRIES(MAX_TRIES)) dut (
        .clk(clk), .rst(rst), .random(random), .req(req), .limit(limit),
        .busy(busy), .valid(valid), .value(value), .fallback(fallback)
    );

    always #5 clk = ~clk;

    // Upstream generator stand-in: one-bit-per-clock LFSR with noise, or a held word.
    always @(negedge clk) begin
        lfsr   = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10] ^ 1'($urandom_range(0, 1))};
        random = (rnd_mode == 1) ? lfsr : rnd_const;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Reference: smallest all-ones mask covering the range; sample every GAP
    // cycles; first in-range sample wins, else subtract once from the last sample.
    function automatic void model(input logic [15:0] lim, output logic [15:0] ev,
                                  output logic efb, output int eedge);
        int span = (lim == 16'd0) ? 65536 : int'(lim);
        int m    = 0;
        int cand = 0;
        while (m + 1 < span) m = m * 2 + 1;
        for (int k = 0; k < int'(MAX_TRIES); k++) begin
            eedge = int'(GAP) * (k + 1) + 1;
            cand  = int'(samp[eedge]) & m;
            if (cand < span) begin
                ev  = 16'(cand);
                efb = 1'b0;
                return;
            end
        end
        ev    = 16'(cand - span);
        efb   = 1'b1;
        eedge = int'(MAX_TRIES * GAP) + 2;
    endfunction

    // Runs one transaction; E0 is the edge that accepts req, edges counted from it.
    task automatic run_txn(input logic [15:0] lim, input bit pre_req, input bit keep_req,
                           input int chg_edge, input logic [15:0] chg_lim,
                           output int vedge, output logic [15:0] vval, output logic vfb,
                           output int pulses, output bit busy_ok);
        vedge = -1; vval = '0; vfb = 1'b0; pulses = 0; busy_ok = 1'b1;
        if (!pre_req) begin
            @(negedge clk);
            req   = 1'b1;
            limit = lim;
        end
        @(posedge clk);
        samp[0] = random;
        #1;
        if (!keep_req) req = 1'b0;
        if (busy !== 1'b1) busy_ok = 1'b0;
        for (int e = 1; e <= MAXE; e++) begin
            @(posedge clk);
            samp[e] = random;
            #1;
            if (e == chg_edge) limit = chg_lim;
            if (valid === 1'b1) begin
                pulses++;
                if (vedge < 0) begin
                    vedge = e; vval = value; vfb = fallback;
                end
            end
            if (vedge < 0 || e == vedge) begin
                if (busy !== 1'b1) busy_ok = 1'b0;
            end else begin
                if (busy !== 1'b0) busy_ok = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset;
        int vedge, pulses; logic [15:0] vval; logic vfb; bit bok;
        #2 rst = 1'b0;
        #1;
        vectors++; if ({valid, busy, fallback, value} !== 19'd0) begin errors++;
            $display("FAIL reset_init: got v=%b b=%b f=%b val=%h expected all 0", valid, busy, fallback, value); end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        rnd_mode = 0; rnd_const = 16'h0321;
        run_txn(16'd1000, 0, 0, -1, '0, vedge, vval, vfb, pulses, bok);
        vectors++; if (vval !== 16'h0321) begin errors++;
            $display("FAIL pre_reset_value: got %h expected 0321", vval); end
        @(negedge clk); req = 1'b1; limit = 16'd16;
        @(posedge clk); #1 req = 1'b0;
        repeat (6) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        vectors++; if ({valid, busy, fallback, value} !== 19'd0) begin errors++;
            $display("FAIL reset_mid: got v=%b b=%b f=%b val=%h expected all 0", valid, busy, fallback, value); end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            vectors++; if (valid !== 1'b0 || busy !== 1'b0) begin errors++;
                $display("FAIL reset_hold: got v=%b b=%b expected 0 0", valid, busy); end
        end
        @(negedge clk); rst = 1'b1;
        rnd_const = 16'h1234;
        run_txn(16'd16, 0, 0, -1, '0, vedge, vval, vfb, pulses, bok);
        vectors++; if (vedge !== 17 || vval !== 16'h0004 || vfb !== 1'b0) begin errors++;
            $display("FAIL reset_recover: got edge=%0d val=%h fb=%b expected 17 0004 0", vedge, vval, vfb); end
        vectors++; if (pulses !== 1 || !bok) begin errors++;
            $display("FAIL reset_recover_hs: got pulses=%0d busy_ok=%b expected 1 1", pulses, bok); end
    endtask

    task automatic test_full_range;
        int vedge, pulses; logic [15:0] vval; logic vfb; bit bok;
        rnd_mode = 0; rnd_const = 16'hBEEF;
        run_txn(16'd0, 0, 0, -1, '0, vedge, vval, vfb, pulses, bok);
        vectors++; if (vedge !== 17 || vval !== 16'hBEEF || vfb !== 1'b0) begin errors++;
            $display("FAIL full_range: got edge=%0d val=%h fb=%b expected 17 BEEF 0", vedge, vval, vfb); end
        vectors++; if (pulses !== 1 || !bok) begin errors++;
            $display("FAIL full_range_hs: got pulses=%0d busy_ok=%b expected 1 1", pulses, bok); end
    endtask

    task automatic test_fallback;
        int vedge, pulses; logic [15:0] vval; logic vfb; bit bok;
        rnd_mode = 0; rnd_const = 16'h0007;
        run_txn(16'd5, 0, 0, -1, '0, vedge, vval, vfb, pulses, bok);
        vectors++; if (vedge !== 130 || vval !== 16'h0002 || vfb !== 1'b1) begin errors++;
            $display("FAIL fallback: got edge=%0d val=%h fb=%b expected 130 0002 1", vedge, vval, vfb); end
        vectors++; if (pulses !== 1 || !bok) begin errors++;
            $display("FAIL fallback_busy: got pulses=%0d busy_ok=%b expected 1 1", pulses, bok); end
    endtask

    task automatic test_degenerate;
        int vedge, pulses; logic [15:0] vval; logic vfb; bit bok;
        rnd_mode = 0; rnd_const = 16'hFFFF;
        run_txn(16'd1, 0, 0, -1, '0, vedge, vval, vfb, pulses, bok);
        vectors++; if (vedge !== 17 || vval !== 16'h0000 || vfb !== 1'b0) begin errors++;
            $display("FAIL degenerate: got edge=%0d val=%h fb=%b expected 17 0000 0", vedge, vval, vfb); end
    endtask

    task automatic test_back_to_back;
        int vedge, pulses, eedge; logic [15:0] vval, ev; logic vfb, efb; bit bok;
        rnd_mode = 1;
        run_txn(16'd16, 0, 1, 5, 16'd3, vedge, vval, vfb, pulses, bok);
        model(16'd16, ev, efb, eedge);
        vectors++; if (vedge !== eedge || vval !== ev || vfb !== efb) begin errors++;
            $display("FAIL b2b_first: got edge=%0d val=%h fb=%b expected %0d %h %b", vedge, vval, vfb, eedge, ev, efb); end
        vectors++; if (pulses !== 1 || !bok) begin errors++;
            $display("FAIL b2b_first_hs: got pulses=%0d busy_ok=%b expected 1 1", pulses, bok); end
        run_txn(16'd3, 1, 0, -1, '0, vedge, vval, vfb, pulses, bok);
        model(16'd3, ev, efb, eedge);
        vectors++; if (vedge !== eedge || vval !== ev || vfb !== efb || vval >= 16'd3) begin errors++;
            $display("FAIL b2b_second: got edge=%0d val=%h fb=%b expected %0d %h %b", vedge, vval, vfb, eedge, ev, efb); end
        vectors++; if (pulses !== 1 || !bok) begin errors++;
            $display("FAIL b2b_second_hs: got pulses=%0d busy_ok=%b expected 1 1", pulses, bok); end
    endtask

    task automatic test_model_sweep(input int n, input bit fixed, input logic [15:0] flim);
        int vedge, pulses, eedge; logic [15:0] vval, ev, lim; logic vfb, efb; bit bok;
        logic [15:0] picks [0:5];
        picks[0] = 16'd0; picks[1] = 16'd1; picks[2] = 16'd2;
        picks[3] = 16'd480; picks[4] = 16'd640; picks[5] = 16'h8001;
        rnd_mode = 1;
        for (int i = 0; i < n; i++) begin
            if (fixed) lim = flim;
            else if (i < 6) lim = picks[i];
            else lim = 16'($urandom_range(0, 65535)) >> $urandom_range(0, 15);
            run_txn(lim, 0, 0, -1, '0, vedge, vval, vfb, pulses, bok);
            model(lim, ev, efb, eedge);
            vectors++; if (vedge !== eedge || vval !== ev || vfb !== efb) begin errors++;
                $display("FAIL sweep_value lim=%0d: got edge=%0d val=%0d fb=%b expected %0d %0d %b",
                         lim, vedge, vval, vfb, eedge, ev, efb); end
            vectors++; if (lim != 16'd0 && vval >= lim) begin errors++;
                $display("FAIL sweep_range lim=%0d: got %0d expected below limit", lim, vval); end
            vectors++; if (pulses !== 1 || !bok) begin errors++;
                $display("FAIL sweep_hs lim=%0d: got pulses=%0d busy_ok=%b expected 1 1", lim, pulses, bok); end
        end
    endtask

    task automatic test_integration_reset;
        int vedge, pulses, eedge; logic [15:0] vval, ev; logic vfb, efb; bit bok;
        rnd_mode = 1;
        @(negedge clk); req = 1'b1; limit = 16'd480;
        @(posedge clk); #1 req = 1'b0;
        repeat (8) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        vectors++; if (valid !== 1'b0 || busy !== 1'b0) begin errors++;
            $display("FAIL int_reset: got v=%b b=%b expected 0 0", valid, busy); end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            vectors++; if (valid !== 1'b0) begin errors++;
                $display("FAIL int_reset_hold: got v=%b expected 0", valid); end
        end
        @(negedge clk); rst = 1'b1;
        run_txn(16'd480, 0, 0, -1, '0, vedge, vval, vfb, pulses, bok);
        model(16'd480, ev, efb, eedge);
        vectors++; if (vedge !== eedge || vval !== ev || vfb !== efb || pulses !== 1 || !bok) begin errors++;
            $display("FAIL int_recover: got edge=%0d val=%0d fb=%b pulses=%0d expected %0d %0d %b 1",
                     vedge, vval, vfb, pulses, eedge, ev, efb); end
    endtask

    initial begin
        test_reset();
        test_full_range();
        test_fallback();
        test_degenerate();
        test_back_to_back();
        test_model_sweep(40, 1'b0, '0);
        test_model_sweep(1000, 1'b1, 16'd480);
        test_integration_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/random_range.md
Name: random_range

Overview:
- Sits directly downstream of the LFSR/noise random generator and consumes its free-running 16-bit `random` word.
- On request, returns one value uniformly distributed in [0, limit) by rejection sampling. Used for things like sprite positions (e.g. limit=640 or 480) and colours.
- Waits GAP cycles between samples, so each draw uses fresh LFSR bits; the source shifts only one bit per clock.
- After MAX_TRIES rejections it falls back to a single subtraction, which bounds latency.

Parameters:
- GAP, 16, cycles between successive samples of `random` (1..65535).
- MAX_TRIES, 8, rejected samples allowed before the fallback reduction (1..255).

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  reset; asynchronous, active-low (low = in reset).
- random  input  16  free-running word from the upstream generator.
- req  input  1  start request; sampled only in IDLE.
- limit  input  16  exclusive upper bound; 0 means 65536 (full range). Latched when req is accepted.
- busy  output  1  high in every state except IDLE.
- valid  output  1  one-cycle pulse: `value` is new.
- value  output  16  result; held until the next transaction completes.
- fallback  output  1  set with valid when the result came from the reduction path; held with `value`.

Behaviour:
- Reset: with rst low, asynchronously clear everything:
  - state=IDLE, valid=0, value=0, fallback=0, busy=0;
  - gap counter, try counter, latched limit and mask all 0.
  - Reset mid-transaction aborts it; no valid is produced.
- States: IDLE, MASK, DRAW, REDUCE, DONE.
- IDLE:
  - On an edge with req=1: latch limit into lim, go to MASK.
  - req=0: stay.
- MASK (1 cycle):
  - mask = all ones at and below the highest set bit of (lim-1), computed in 16-bit wrap.
  - So lim=0 gives FFFF, lim=1 gives 0000, lim=16 gives 000F, lim=480 gives 01FF.
  - Load gap counter with GAP-1 and try counter with 0. Go to DRAW.
- DRAW:
  - While the gap counter is not 0: decrement it.
  - When it is 0, compute cand = random & mask.
  - Accept if lim==0 or cand < lim (unsigned): value <= cand, fallback <= 0, go to DONE.
  - Otherwise, if the try counter == MAX_TRIES-1: hold cand, go to REDUCE.
  - Otherwise: increment the try counter, reload the gap counter with GAP-1, stay in DRAW.
- REDUCE (1 cycle): value <= cand - lim, fallback <= 1, go to DONE. Because mask < 2*lim, one subtraction always lands in range.
- DONE (1 cycle): valid=1, busy=1, then go to IDLE.
- Latency, counted from the edge that accepts req = E0:
  - First sample is taken at edge E(GAP+1); valid is high in the following cycle.
  - Each rejection adds GAP cycles.
  - With the fallback, valid is high after edge E(MAX_TRIES*GAP+2).
- req while busy (including DONE) is ignored and not queued. If req is held high, the next transaction starts on the edge after DONE, i.e. back-to-back transactions are spaced by one IDLE cycle.
- limit changes while busy have no effect.
- valid is never high for two consecutive cycles.
- busy is registered and rises the cycle after req is accepted.

Test Plan:
- Reset: rst=0 mid-run -> valid=0, value=0, busy=0, fallback=0 immediately; release rst, req with limit=16, random=0x1234 -> valid after E17 with value=0x0004, fallback=0.
- Full range: limit=0, random held at 0xBEEF -> value=0xBEEF, valid after E17, fallback=0.
- Fallback: limit=5 (mask 0007), random held at 0x0007 -> 8 rejections, valid after E130, value=0x0002, fallback=1, busy=1 from E1 through the DONE cycle.
- Degenerate bound: limit=1, random=0xFFFF -> value=0, valid after E17.
- Handshake: req held high, limit changed from 16 to 3 during DRAW -> first result uses 16; second transaction starts one IDLE cycle after DONE, uses 3, and gives exactly one valid pulse per transaction.
- Integration: connect the upstream generator with toggling noise, 1000 requests at limit=480 -> every value <480, every valid lasts one cycle, no fallback result ≥480; then reset mid-DRAW -> no valid, next request completes normally.
